alu_stream_responder: RTL and testbench



---
 rtl/alu_stream_responder.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_stream_responder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stream_responder.sv
// ---------------------------------------------------------------------------
// alu_stream_responder
//
// Purpose:
//   Accepts ALU requests (operand A, operand B, 3-bit opcode) on a
//   valid/ready channel, computes the result on the accepting edge and
//   queues it in a DEPTH-entry FIFO. Results are returned in strict order
//   on a second valid/ready channel.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous, active-high reset
//   req_valid   in   request present
//   req_ready   out  request can be accepted (registered, count based)
//   req_a       in   operand A [WIDTH]
//   req_b       in   operand B [WIDTH]
//   req_opcode  in   operation select [3]
//   rsp_valid   out  result present at FIFO head
//   rsp_ready   in   consumer takes the head result this cycle
//   rsp_result  out  head result [WIDTH]
//   rsp_count   out  FIFO occupancy [$clog2(DEPTH)+1]
//   rsp_flags   out  head status flags {ovf, neg, carry, zero}
//                    (only when ALU_STATUS_EN is defined)
//
// Optional feature macro: ALU_STATUS_EN
// ---------------------------------------------------------------------------
module alu_stream_responder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  input  logic [2:0]             req_opcode,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic [$clog2(DEPTH):0] rsp_count
`ifdef ALU_STATUS_EN
  ,
  output logic [3:0]             rsp_flags
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  // ALU datapath; shift amount uses only the low log2(WIDTH) bits of B.
  function automatic logic [WIDTH-1:0] f_alu(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0]       op);
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] res;
    sh = b[SHW-1:0];
    case (op)
      3'b000:  res = a + b;
      3'b001:  res = a - b;
      3'b010:  res = a & b;
      3'b011:  res = a | b;
      3'b100:  res = a ^ b;
      3'b101:  res = a << sh;
      3'b110:  res = a >> sh;
      3'b111:  res = a;
      default: res = a;
    endcase
    return res;
  endfunction

`ifdef ALU_STATUS_EN
  // Status flags {overflow, negative, carry/borrow, zero} for one result.
  function automatic logic [3:0] f_flags(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [2:0]       op,
                                         input logic [WIDTH-1:0] res);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] shl;
    logic           carry;
    logic           ovf;
    sum   = {1'b0, a} + {1'b0, b};
    // Widened shift keeps the last bit shifted out in the top position.
    shl   = {1'b0, a} << b[SHW-1:0];
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      3'b000: begin
        carry = sum[WIDTH];
        ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b001: begin
        carry = (a < b);
        ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b101: begin
        carry = shl[WIDTH];
        ovf   = 1'b0;
      end
      default: begin
        carry = 1'b0;
        ovf   = 1'b0;
      end
    endcase
    return {ovf, res[WIDTH-1], carry, (res == {WIDTH{1'b0}})};
  endfunction
`endif

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             r_req_ready;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_result;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_alu;
  logic [AW-1:0]    w_wptr_nxt;
  logic [AW-1:0]    w_rptr_nxt;
  logic [AW:0]      w_count_nxt;
  logic [WIDTH-1:0] w_head_nxt;
  logic             w_bypass;

`ifdef ALU_STATUS_EN
  logic [3:0] r_flag_mem [DEPTH];
  logic [3:0] r_rsp_flags;
  logic [3:0] w_flags;
  logic [3:0] w_head_flags_nxt;
`endif

  // Handshakes and next-state for pointers, count and head register.
  always_comb begin
    w_push      = req_valid && r_req_ready;
    w_pop       = r_rsp_valid && rsp_ready;
    w_alu       = f_alu(req_a, req_b, req_opcode);
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    w_head_nxt  = {WIDTH{1'b0}};
    if (w_push) begin
      w_wptr_nxt = r_wptr + PTR_ONE;
    end else begin
      w_wptr_nxt = r_wptr;
    end
    if (w_pop) begin
      w_rptr_nxt = r_rptr + PTR_ONE;
    end else begin
      w_rptr_nxt = r_rptr;
    end
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
    // New entry becomes the head when it lands where the read pointer goes.
    w_bypass = w_push && (r_wptr == w_rptr_nxt);
    if (w_count_nxt == {(AW+1){1'b0}}) begin
      w_head_nxt = {WIDTH{1'b0}};
    end else if (w_bypass) begin
      w_head_nxt = w_alu;
    end else begin
      w_head_nxt = r_mem[w_rptr_nxt];
    end
  end

`ifdef ALU_STATUS_EN
  // Flag computation and head-flag selection, mirroring the result path.
  always_comb begin
    w_flags          = f_flags(req_a, req_b, req_opcode, w_alu);
    w_head_flags_nxt = 4'b0000;
    if (w_count_nxt == {(AW+1){1'b0}}) begin
      w_head_flags_nxt = 4'b0000;
    end else if (w_bypass) begin
      w_head_flags_nxt = w_flags;
    end else begin
      w_head_flags_nxt = r_flag_mem[w_rptr_nxt];
    end
  end

  // Flag storage (contents need no reset) and registered head flags.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_flag_mem[r_wptr] <= w_flags;
    end
  end

  // Registered head flags, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_flags <= 4'b0000;
    end else begin
      r_rsp_flags <= w_head_flags_nxt;
    end
  end

  assign rsp_flags = r_rsp_flags;
`endif

  // Result storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_alu;
    end
  end

  // Pointers, occupancy and registered channel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr       <= {AW{1'b0}};
      r_rptr       <= {AW{1'b0}};
      r_count      <= {(AW+1){1'b0}};
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= {WIDTH{1'b0}};
    end else begin
      r_wptr       <= w_wptr_nxt;
      r_rptr       <= w_rptr_nxt;
      r_count      <= w_count_nxt;
      r_req_ready  <= (w_count_nxt < FULL_CNT);
      r_rsp_valid  <= (w_count_nxt != {(AW+1){1'b0}});
      r_rsp_result <= w_head_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_result = r_rsp_result;
  assign rsp_count  = r_count;

endmodule

// File: tb/tb_alu_stream_responder.sv
// ---------------------------------------------------------------------------
// tb_alu_stream_responder
//
// Purpose: randomized and directed stimulus for alu_stream_responder with a
// queue scoreboard. A monitor pushes the reference-model result for every
// accepted request and pops/compares on every consumed response.
// Build with ALU_STATUS_EN defined to also compare rsp_flags.
// ---------------------------------------------------------------------------
module tb_alu_stream_responder;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk        = 1'b0;
  logic         rst        = 1'b1;
  logic         req_valid  = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_a      = 8'h00;
  logic [W-1:0] req_b      = 8'h00;
  logic [2:0]   req_opcode = 3'b000;
  logic         rsp_valid;
  logic         rsp_ready  = 1'b0;
  logic [W-1:0] rsp_result;
  logic [2:0]   rsp_count;
`ifdef ALU_STATUS_EN
  logic [3:0]   rsp_flags;
`endif

  alu_stream_responder #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
`ifdef ALU_STATUS_EN
    .rsp_flags  (rsp_flags),
`endif
    .rsp_count  (rsp_count)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          m_total = 0;
  int          m_pass  = 0;
  int          pops    = 0;
  bit          done    = 1'b0;
  logic [11:0] sb_q [$];
  logic [7:0]  fill_exp [4] = '{8'hFE, 8'h30, 8'h02, 8'h40};

  // Reference model: {ovf, neg, carry, zero, result[7:0]} from plain integers.
  function automatic logic [11:0] model(input int a, input int b, input int op);
    int   r, full, sa, sb, sh;
    logic fz, fc, fn, fv;
    r  = 0;
    fc = 1'b0;
    fv = 1'b0;
    sa = (a >= 2**(W-1)) ? a - 2**W : a;
    sb = (b >= 2**(W-1)) ? b - 2**W : b;
    sh = b % W;
    case (op)
      0: begin
        full = a + b;
        r    = full % 2**W;
        fc   = (full >= 2**W);
        fv   = (sa + sb > 2**(W-1) - 1) || (sa + sb < -(2**(W-1)));
      end
      1: begin
        full = a - b;
        r    = (full + 2**W) % 2**W;
        fc   = (a < b);
        fv   = (sa - sb > 2**(W-1) - 1) || (sa - sb < -(2**(W-1)));
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin
        r  = (a * (2**sh)) % 2**W;
        fc = (sh == 0) ? 1'b0 : (((a >> (W - sh)) & 1) == 1);
      end
      6: r = a / (2**sh);
      default: r = a;
    endcase
    fz = (r == 0);
    fn = (r >= 2**(W-1));
    return {fv, fn, fc, fz, r[7:0]};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic mchk(input string name, input int act, input int exp);
    m_total++;
    if (act == exp) m_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Present one request and hold it until an edge accepts it (bounded).
  task automatic send(input int a, input int b, input int op);
    bit acc;
    int t;
    acc        = 1'b0;
    t          = 0;
    req_a      = a[7:0];
    req_b      = b[7:0];
    req_opcode = op[2:0];
    req_valid  = 1'b1;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) begin
      n_total++;
      $display("FAIL send_timeout: request op=%0d never accepted", op);
    end
  endtask

  task automatic send_rand();
    send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
         int'($urandom_range(0, 7)));
  endtask

  // Let the FIFO drain with rsp_ready held high (bounded).
  task automatic wait_empty();
    int t;
    t = 0;
    rsp_ready = 1'b1;
    while ((rsp_count != 3'd0 || rsp_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_empty", int'(rsp_count), 0);
  endtask

  // Scoreboard monitor: hold-stability, pop/compare, then push on accept.
  logic         prev_hold;
  logic [W-1:0] prev_res;
`ifdef ALU_STATUS_EN
  logic [3:0]   prev_flags;
`endif
  logic [11:0]  exp_e;
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      sb_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        mchk("hold_valid", int'(rsp_valid), 1);
        mchk("hold_result", int'(rsp_result), int'(prev_res));
`ifdef ALU_STATUS_EN
        mchk("hold_flags", int'(rsp_flags), int'(prev_flags));
`endif
      end
      if (rsp_valid && rsp_ready) begin
        pops++;
        if (sb_q.size() == 0) begin
          m_total++;
          $display("FAIL unexpected_rsp: result 0x%0h with empty scoreboard", rsp_result);
        end else begin
          exp_e = sb_q.pop_front();
          mchk("rsp_result", int'(rsp_result), int'(exp_e[7:0]));
`ifdef ALU_STATUS_EN
          mchk("rsp_flags", int'(rsp_flags), int'(exp_e[11:8]));
`endif
        end
      end
      if (req_valid && req_ready) begin
        sb_q.push_back(model(int'(req_a), int'(req_b), int'(req_opcode)));
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_res  = rsp_result;
`ifdef ALU_STATUS_EN
      prev_flags = rsp_flags;
`endif
    end
  end

  int pops0;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_result", int'(rsp_result), 0);
    chk("rst_rsp_count", int'(rsp_count), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(req_ready), 1);

    // Single ADD, one-cycle latency
    rsp_ready = 1'b1;
    send(8'h7F, 8'h01, 0);
    req_valid = 1'b0;
    chk("add_valid", int'(rsp_valid), 1);
    chk("add_count", int'(rsp_count), 1);
    chk("add_result", int'(rsp_result), 8'h80);
`ifdef ALU_STATUS_EN
    chk("add_flags", int'(rsp_flags), 4'b1100);
`endif
    @(posedge clk);
    #1;
    chk("add_count_after", int'(rsp_count), 0);
    chk("add_valid_after", int'(rsp_valid), 0);

    // Fill to full with consumer stalled, fifth request held pending
    rsp_ready = 1'b0;
    send(8'h05, 8'h07, 1);
    send(8'hF0, 8'h3C, 2);
    send(8'h81, 8'h01, 5);
    send(8'h81, 8'h09, 6);
    req_a = 8'h11; req_b = 8'h22; req_opcode = 3'b000; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("full_count", int'(rsp_count), 4);
      chk("full_ready", int'(req_ready), 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
`ifdef ALU_STATUS_EN
    chk("sub_carry", int'(rsp_flags[1]), 1);
    chk("sub_neg", int'(rsp_flags[2]), 1);
`endif
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fill_drain", int'(rsp_result), int'(fill_exp[i]));
      @(posedge clk);
      #1;
    end
    chk("fill_empty", int'(rsp_count), 0);

    // Simultaneous accept and pop at count 2
    rsp_ready = 1'b0;
    send_rand();
    send_rand();
    chk("simul_start", int'(rsp_count), 2);
    rsp_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send_rand();
      chk("simul_count", int'(rsp_count), 2);
    end
    req_valid = 1'b0;
    wait_empty();

    // Backpressure with alternating rsp_ready, 100 transactions
    pops0 = pops;
    done  = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid = 1'b0;
            @(posedge clk);
            #1;
          end
          send_rand();
        end
        req_valid = 1'b0;
        done = 1'b1;
      end
      begin
        int k;
        k = 0;
        while (!done) begin
          rsp_ready = (k % 2 == 0);
          @(posedge clk);
          #1;
          k++;
        end
      end
    join
    wait_empty();
    chk("bp_pops", pops - pops0, 100);

    // Asynchronous reset with three queued entries
    rsp_ready = 1'b0;
    send_rand();
    send_rand();
    send_rand();
    req_valid = 1'b0;
    chk("pre_rst_count", int'(rsp_count), 3);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(rsp_valid), 0);
    chk("async_rst_count", int'(rsp_count), 0);
    chk("async_rst_ready", int'(req_ready), 0);
    rst = 1'b0;
    pops0 = pops;
    rsp_ready = 1'b1;
    send(8'hAA, 8'hFF, 4);
    req_valid = 1'b0;
    chk("xor_result", int'(rsp_result), 8'h55);
    repeat (4) @(posedge clk);
    #1;
    chk("post_rst_pops", pops - pops0, 1);
    chk("post_rst_valid", int'(rsp_valid), 0);

    // Boundary operations all yielding zero
    rsp_ready = 1'b0;
    send(8'hFF, 8'h01, 0);
    send(8'h00, int'($urandom_range(0, 255)), 7);
    send(8'h00, 8'h00, 3);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("boundary_result", int'(rsp_result), 0);
`ifdef ALU_STATUS_EN
      chk("boundary_zero", int'(rsp_flags[0]), 1);
      if (i == 0) chk("boundary_add_carry", int'(rsp_flags[1]), 1);
`endif
      @(posedge clk);
      #1;
    end
    wait_empty();
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass + m_pass, n_total + m_total);
    $finish;
  end

endmodule
